// File: rtl/timer_pkg.sv
// timer_pkg -- shared definitions for the timer_counter_n slice.
//   cks_t : prescaler select encoding (CKS_DIV1..CKS_DIV8)
//   dir_t : count direction (DIR_UP=0, DIR_DOWN=1)
//   psc_mask() : prescaler bits that must be all ones for a tick
package timer_pkg;

  typedef enum logic [1:0] {
    CKS_DIV1 = 2'b00,
    CKS_DIV2 = 2'b01,
    CKS_DIV4 = 2'b10,
    CKS_DIV8 = 2'b11
  } cks_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Smallest prescaler able to express the div8 ratio.
  localparam int unsigned PSC_MIN_W = 3;

  // div 2^k ticks when the low k prescaler bits are all ones; div1 has an
  // empty mask and therefore ticks every enabled cycle.
  function automatic logic [PSC_MIN_W-1:0] psc_mask(input cks_t sel);
    logic [PSC_MIN_W-1:0] m;
    m = '0;
    case (sel)
      CKS_DIV1: m = 3'b000;
      CKS_DIV2: m = 3'b001;
      CKS_DIV4: m = 3'b011;
      CKS_DIV8: m = 3'b111;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler -- free-running prescaler and count tick generator.
//   clk_in       : clock, rising edge
//   preset       : asynchronous active-high reset
//   en           : prescaler runs while high, held at 0 while low
//   load         : holds the prescaler at 0 and suppresses the tick
//   count_enable : external gate on the tick
//   cks          : divide select (see timer_pkg::cks_t)
//   tick         : combinational one-cycle count strobe
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PSC_W = 3
) (
  input  logic       clk_in,
  input  logic       preset,
  input  logic       en,
  input  logic       load,
  input  logic       count_enable,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [PSC_W-1:0]     psc;
  logic [PSC_MIN_W-1:0] mask;

  always_ff @(posedge clk_in or posedge preset) begin
    if (preset) begin
      psc <= '0;
    end else if (!en || load) begin
      psc <= '0;
    end else begin
      psc <= psc + PSC_W'(1);
    end
  end

  // The prescaler keeps running across a cks change, so a new ratio takes
  // effect against the current prescaler phase rather than restarting.
  always_comb begin
    mask = psc_mask(cks_t'(cks));
    tick = count_enable & en & ~load & ((psc[PSC_MIN_W-1:0] & mask) == mask);
  end

endmodule

// File: rtl/timer_counter_n.sv
// timer_counter_n -- up/down timer with prescaler, auto-reload, sticky
// overflow/underflow flags and an optional compare-match unit.
//
// Optional feature: define TIMER_COUNTER_N_CMP_EN to build the compare-match
// logic; without it cmp_pulse/cmp_flag are tied low and reg_cmp/cmp_clr are
// ignored.
//
// Ports:
//   clk_in       : clock, rising edge
//   preset       : asynchronous active-high reset
//   en           : timer enable
//   load         : synchronous load of reg_tdr into cnt (highest priority)
//   ud           : direction, 0 = up, 1 = down
//   count_enable : external count gate
//   cks          : prescaler select 00/01/10/11 = div1/2/4/8
//   reload_en    : reload reg_tdr on wrap instead of free wrap
//   reg_tdr      : load / reload value
//   ovf_clr      : write-1-to-clear for ovf_flag
//   udf_clr      : write-1-to-clear for udf_flag
//   reg_cmp      : compare value
//   cmp_clr      : write-1-to-clear for cmp_flag
//   cnt          : counter value
//   last_cnt     : cnt from the previous cycle
//   ovf_pulse    : one cycle, aligned with the first wrapped cnt (up)
//   udf_pulse    : one cycle, aligned with the first wrapped cnt (down)
//   ovf_flag     : sticky overflow
//   udf_flag     : sticky underflow
//   cmp_pulse    : one cycle, aligned with cnt first equal to reg_cmp
//   cmp_flag     : sticky compare match
module timer_counter_n
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PSC_W = 3
) (
  input  logic             clk_in,
  input  logic             preset,
  input  logic             en,
  input  logic             load,
  input  logic             ud,
  input  logic             count_enable,
  input  logic [1:0]       cks,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] reg_tdr,
  input  logic             ovf_clr,
  input  logic             udf_clr,
  input  logic [WIDTH-1:0] reg_cmp,
  input  logic             cmp_clr,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] last_cnt,
  output logic             ovf_pulse,
  output logic             udf_pulse,
  output logic             ovf_flag,
  output logic             udf_flag,
  output logic             cmp_pulse,
  output logic             cmp_flag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             tick;
  logic [WIDTH-1:0] cnt_nx;
  logic             ovf_nx;
  logic             udf_nx;
  logic             upd;

  timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk_in       (clk_in),
    .preset       (preset),
    .en           (en),
    .load         (load),
    .count_enable (count_enable),
    .cks          (cks),
    .tick         (tick)
  );

  // tick already carries en and ~load, so load > tick > hold falls out here.
  always_comb begin
    cnt_nx = cnt;
    ovf_nx = 1'b0;
    udf_nx = 1'b0;
    upd    = 1'b0;
    if (load) begin
      cnt_nx = reg_tdr;
      upd    = 1'b1;
    end else if (tick) begin
      upd = 1'b1;
      if (dir_t'(ud) == DIR_DOWN) begin
        if (cnt == '0) begin
          udf_nx = 1'b1;
          cnt_nx = reload_en ? reg_tdr : '1;
        end else begin
          cnt_nx = cnt - ONE;
        end
      end else begin
        if (cnt == '1) begin
          ovf_nx = 1'b1;
          cnt_nx = reload_en ? reg_tdr : '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge preset) begin
    if (preset) begin
      cnt       <= '0;
      last_cnt  <= '0;
      ovf_pulse <= 1'b0;
      udf_pulse <= 1'b0;
      ovf_flag  <= 1'b0;
      udf_flag  <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      last_cnt  <= cnt;
      ovf_pulse <= ovf_nx;
      udf_pulse <= udf_nx;
      // set beats a simultaneous clear
      if (ovf_nx) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end
      if (udf_nx) begin
        udf_flag <= 1'b1;
      end else if (udf_clr) begin
        udf_flag <= 1'b0;
      end
    end
  end

`ifdef TIMER_COUNTER_N_CMP_EN
  logic cmp_hit;

  // Match is judged on the value cnt is about to take, so the registered
  // pulse lines up with the first cycle cnt shows reg_cmp.
  assign cmp_hit = upd && (cnt_nx == reg_cmp);

  always_ff @(posedge clk_in or posedge preset) begin
    if (preset) begin
      cmp_pulse <= 1'b0;
      cmp_flag  <= 1'b0;
    end else begin
      cmp_pulse <= cmp_hit;
      if (cmp_hit) begin
        cmp_flag <= 1'b1;
      end else if (cmp_clr) begin
        cmp_flag <= 1'b0;
      end
    end
  end
`else
  // Compare inputs are deliberately left without a load; this sink keeps
  // them visibly consumed without creating any logic.
  logic unused_cmp;
  assign unused_cmp = &{1'b0, reg_cmp, cmp_clr, upd};
  assign cmp_pulse  = 1'b0;
  assign cmp_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter_n.sv
module tb_timer_counter_n;

`ifdef TIMER_COUNTER_N_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       preset = 1'b0;
  logic       en = 1'b0, load = 1'b0, ud = 1'b0, count_enable = 1'b0;
  logic [1:0] cks = 2'b00;
  logic       reload_en = 1'b0;
  logic [7:0] reg_tdr = 8'h00;
  logic       ovf_clr = 1'b0, udf_clr = 1'b0;
  logic [7:0] reg_cmp = 8'h05;
  logic       cmp_clr = 1'b0;
  logic [7:0] cnt, last_cnt;
  logic       ovf_pulse, udf_pulse, ovf_flag, udf_flag, cmp_pulse, cmp_flag;

  timer_counter_n #(
    .WIDTH (8),
    .PSC_W (3)
  ) dut (
    .clk_in       (clk_in),
    .preset       (preset),
    .en           (en),
    .load         (load),
    .ud           (ud),
    .count_enable (count_enable),
    .cks          (cks),
    .reload_en    (reload_en),
    .reg_tdr      (reg_tdr),
    .ovf_clr      (ovf_clr),
    .udf_clr      (udf_clr),
    .reg_cmp      (reg_cmp),
    .cmp_clr      (cmp_clr),
    .cnt          (cnt),
    .last_cnt     (last_cnt),
    .ovf_pulse    (ovf_pulse),
    .udf_pulse    (udf_pulse),
    .ovf_flag     (ovf_flag),
    .udf_flag     (udf_flag),
    .cmp_pulse    (cmp_pulse),
    .cmp_flag     (cmp_flag)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       ld, en, ud, ce;
    logic [1:0] cks;
    logic       rl;
    logic [7:0] tdr;
    logic       oc, uc;
    logic [7:0] cnt, last;
    logic       op, up, of, uf;
  } vec_t;

  typedef struct {
    string      tag;
    logic [7:0] cnt, last;
    logic       op, up, of, uf;
    logic       chk_cmp;
    logic       cp, cf;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.tag, ".cnt"}, cnt, e.cnt);
    chk({e.tag, ".last_cnt"}, last_cnt, e.last);
    chk({e.tag, ".ovf_pulse"}, {7'd0, ovf_pulse}, {7'd0, e.op});
    chk({e.tag, ".udf_pulse"}, {7'd0, udf_pulse}, {7'd0, e.up});
    chk({e.tag, ".ovf_flag"}, {7'd0, ovf_flag}, {7'd0, e.of});
    chk({e.tag, ".udf_flag"}, {7'd0, udf_flag}, {7'd0, e.uf});
    if (e.chk_cmp) begin
      chk({e.tag, ".cmp_pulse"}, {7'd0, cmp_pulse}, {7'd0, e.cp});
      chk({e.tag, ".cmp_flag"}, {7'd0, cmp_flag}, {7'd0, e.cf});
    end
  endtask

  task automatic drive(input logic l, input logic e, input logic u, input logic c,
                       input logic [1:0] k, input logic r, input logic [7:0] t,
                       input logic oc, input logic uc);
    load = l; en = e; ud = u; count_enable = c; cks = k;
    reload_en = r; reg_tdr = t; ovf_clr = oc; udf_clr = uc;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c, input logic [7:0] l,
                            input logic op, input logic up, input logic of, input logic uf,
                            input logic chkc, input logic cp, input logic cf);
    exp_t e;
    e.tag = tag; e.cnt = c; e.last = l; e.op = op; e.up = up; e.of = of; e.uf = uf;
    e.chk_cmp = chkc; e.cp = cp; e.cf = cf;
    sb.push_back(e);
  endtask

  // One clock: outputs sampled 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue want entry");
    end else begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ld en ud ce cks rl tdr oc uc | cnt last op up of uf
    tbl[0]  = '{1,0,0,0,2'b00,0,8'hFD,0,0, 8'hFD,8'h00,0,0,0,0};
    tbl[1]  = '{0,1,0,1,2'b00,0,8'hFD,0,0, 8'hFE,8'hFD,0,0,0,0};
    tbl[2]  = '{0,1,0,1,2'b00,0,8'h00,0,0, 8'hFF,8'hFE,0,0,0,0};
    tbl[3]  = '{0,1,0,1,2'b00,0,8'h00,0,0, 8'h00,8'hFF,1,0,1,0};
    tbl[4]  = '{0,1,0,0,2'b00,0,8'h00,0,0, 8'h00,8'h00,0,0,1,0};
    tbl[5]  = '{0,0,0,0,2'b00,0,8'h00,1,0, 8'h00,8'h00,0,0,0,0};
    tbl[6]  = '{1,0,0,0,2'b00,0,8'hFF,0,0, 8'hFF,8'h00,0,0,0,0};
    tbl[7]  = '{0,1,0,1,2'b00,0,8'h00,1,0, 8'h00,8'hFF,1,0,1,0};
    tbl[8]  = '{0,1,0,0,2'b00,0,8'h00,1,0, 8'h00,8'h00,0,0,0,0};
    tbl[9]  = '{1,0,0,0,2'b00,0,8'h01,0,0, 8'h01,8'h00,0,0,0,0};
    tbl[10] = '{0,1,1,1,2'b00,1,8'h10,0,0, 8'h00,8'h01,0,0,0,0};
    tbl[11] = '{0,1,1,1,2'b00,1,8'h10,0,0, 8'h10,8'h00,0,1,0,1};
    tbl[12] = '{0,1,1,1,2'b00,1,8'h10,0,0, 8'h0F,8'h10,0,0,0,1};
    tbl[13] = '{0,1,0,1,2'b00,1,8'h10,0,0, 8'h10,8'h0F,0,0,0,1};
    tbl[14] = '{1,1,1,1,2'b00,0,8'h00,0,0, 8'h00,8'h10,0,0,0,1};
    tbl[15] = '{0,1,1,1,2'b00,0,8'h00,0,0, 8'hFF,8'h00,0,1,0,1};
    tbl[16] = '{0,1,1,0,2'b00,0,8'h00,0,1, 8'hFF,8'hFF,0,0,0,0};
    tbl[17] = '{0,1,0,1,2'b00,1,8'h20,0,0, 8'h20,8'hFF,1,0,1,0};
    tbl[18] = '{1,1,0,1,2'b00,1,8'h7F,0,0, 8'h7F,8'h20,0,0,1,0};
    tbl[19] = '{0,0,0,1,2'b00,0,8'h7F,0,0, 8'h7F,8'h7F,0,0,1,0};

    // Reset state
    #2 preset = 1'b1;
    #1;
    expect_out("reset", 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 0);
    compare(sb.pop_front());
    @(posedge clk_in);
    #1 preset = 1'b0;

    // Table: load, wrap, reload, clear races, direction change, hold
    for (int unsigned i = 0; i < 20; i++) begin
      drive(tbl[i].ld, tbl[i].en, tbl[i].ud, tbl[i].ce, tbl[i].cks,
            tbl[i].rl, tbl[i].tdr, tbl[i].oc, tbl[i].uc);
      expect_out($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].last,
                 tbl[i].op, tbl[i].up, tbl[i].of, tbl[i].uf, 0, 0, 0);
      step();
    end

    // div4 from 0: ticks on cycles 4, 8, 12, 16
    drive(1, 1, 0, 1, 2'b10, 0, 8'h00, 0, 0);
    expect_out("div4_load", 8'h00, 8'h7F, 0, 0, 1, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 1, 2'b10, 0, 8'h00, 0, 0);
    for (int unsigned i = 1; i <= 16; i++) begin
      expect_out($sformatf("div4_c%0d", i), 8'(i / 4), 8'((i - 1) / 4), 0, 0, 1, 0, 0, 0, 0);
      step();
    end

    // Reach cnt=0x55 with prescaler at 2 under div2, then reset mid-cycle
    drive(1, 1, 0, 1, 2'b01, 0, 8'h54, 0, 0);
    expect_out("rst_load", 8'h54, 8'h04, 0, 0, 1, 0, 0, 0, 0);
    step();
    drive(0, 1, 0, 1, 2'b01, 0, 8'h54, 0, 0);
    expect_out("rst_pre1", 8'h54, 8'h54, 0, 0, 1, 0, 0, 0, 0);
    step();
    expect_out("rst_pre2", 8'h55, 8'h54, 0, 0, 1, 0, 0, 0, 0);
    step();
    #2 preset = 1'b1;
    #1;
    expect_out("rst_mid", 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 0);
    compare(sb.pop_front());
    #1 preset = 1'b0;
    expect_out("rst_rel1", 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_out("rst_rel2", 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Compare match at 0x05 counting up from 0x03
    drive(1, 1, 0, 1, 2'b00, 0, 8'h03, 0, 0);
    expect_out("cmp_load", 8'h03, 8'h01, 0, 0, 0, 0, 1, 0, 0);
    step();
    drive(0, 1, 0, 1, 2'b00, 0, 8'h03, 0, 0);
    expect_out("cmp_04", 8'h04, 8'h03, 0, 0, 0, 0, 1, 0, 0);
    step();
    expect_out("cmp_05", 8'h05, 8'h04, 0, 0, 0, 0, 1, CMP_ON, CMP_ON);
    step();
    cmp_clr = 1'b0;
    expect_out("cmp_06", 8'h06, 8'h05, 0, 0, 0, 0, 1, 0, CMP_ON);
    step();
    expect_out("cmp_07", 8'h07, 8'h06, 0, 0, 0, 0, 1, 0, CMP_ON);
    step();
    drive(0, 1, 0, 0, 2'b00, 0, 8'h03, 0, 0);
    cmp_clr = 1'b1;
    expect_out("cmp_clr", 8'h07, 8'h07, 0, 0, 0, 0, 1, 0, 0);
    step();
    cmp_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
